slurm_cpu_fetch_queue: RTL and testbench
========================================

Name: slurm_cpu_fetch_queue

Overview:
- Parametrised instruction prefetch unit for the slurm CPU family.
- Sits between the program counter/branch logic and the memory arbiter.
- Issues sequential instruction fetches ahead of decode and buffers up to DEPTH words with their addresses in a FIFO.
- Presents one instruction per cycle to pipeline stage 0, with consumer back-pressure, branch flush and halt/wake.

Parameters:
BITS, 16, instruction/data word width
ADDRESS_BITS, 16, memory address width
DEPTH, 4, FIFO entries; power of two, minimum 2
PC_INCR, 2, address increment per fetched word (byte addressing)
RESET_VECTOR, 0, fetch address after reset

Ports:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  synchronous reset, active-high
mem_address  out  ADDRESS_BITS  fetch address to arbiter
mem_valid  out  1  fetch request
mem_ready  in  1  grant from arbiter; request accepted when mem_valid&&mem_ready
mem_in  in  BITS  fetched word; valid exactly 1 cycle after acceptance
load_pc  in  1  branch/ret/interrupt redirect strobe
pc_in  in  ADDRESS_BITS  redirect target
halt  in  1  stop issuing fetches (pulse)
wake  in  1  resume fetching (pulse)
instr_out  out  BITS  FIFO head instruction
instr_pc  out  ADDRESS_BITS  address of instr_out
instr_pc_plus  out  ADDRESS_BITS  instr_pc+PC_INCR (return address)
instr_valid  out  1  head entry valid
instr_ready  in  1  consumer takes head this cycle
halted  out  1  fetch is halted
occupancy  out  clog2(DEPTH)+1  buffered entries plus the in-flight fetch

Behaviour:
- Reset state (RST high at a clock edge):
  - fetch_pc=RESET_VECTOR.
  - rd_ptr=wr_ptr=0, count=0, inflight=0, halted=0.
  - Outputs: instr_valid=0, mem_valid=0, occupancy=0; instr_out/instr_pc=0.
- Reset overrides every other input in the same cycle and aborts any in-flight fetch; its return data is ignored.
- occupancy = count + inflight, where inflight is 1 in the cycle after an accepted request.
- mem_valid is combinational: !halted && !load_pc && occupancy<DEPTH. mem_address=fetch_pc.
- The arbiter tolerates withdrawal of mem_valid without a grant.
- On acceptance:
  - fetch_pc <= fetch_pc+PC_INCR, modulo 2^ADDRESS_BITS, so 0xFFFE wraps to 0x0000.
  - inflight<=1; tag_addr<=fetch_pc.
  - Otherwise inflight<=0.
- Return cycle (inflight=1): {mem_in, tag_addr} is written at wr_ptr and wr_ptr increments, unless load_pc is high that cycle, in which case the word is discarded.
- Pop: instr_valid && instr_ready && !load_pc → rd_ptr increments. instr_valid = count!=0 (registered FIFO head, no bypass).
- Push and pop in the same cycle: count unchanged.
- The FIFO never overflows: occupancy<DEPTH gates issue. Pointers wrap modulo DEPTH.
- Minimum latency: request accepted in cycle 0 → data on mem_in in cycle 1 → instr_valid in cycle 2.
- Sustained rate is 1 word/cycle with mem_ready=1 and instr_ready=1.
- load_pc in cycle N:
  - count<=0 and rd_ptr<=wr_ptr.
  - fetch_pc<=pc_in.
  - Returning data in N is dropped and no pop occurs.
  - No request is issued in N.
  - First new request in N+1, so the first redirected instr_valid appears in N+3.
- halt: halted<=1. Accepted/in-flight fetches complete and the queue drains normally.
- wake: halted<=0. halt and wake together: wake wins.
- load_pc while halted: redirect applies and halted stays 1.
- instr_ready while instr_valid=0 has no effect.

Test Plan:
- Reset, mem_ready=1, instr_ready=1 → requests at 0x0000, 0x0002, 0x0004… one per cycle; instr_valid first in cycle 2; instr_pc follows fetch order; instr_pc_plus=instr_pc+2.
- instr_ready=0 held, mem_ready=1, DEPTH=4 → exactly 4 requests accepted, then mem_valid=0 and occupancy=4. Raise instr_ready → 4 pops in order, issuing resumes, no data lost or duplicated.
- load_pc=1, pc_in=0x1230 in the same cycle as returning data for 0x0008 and a full queue → 0x0008 dropped, instr_valid=0 next cycle, next request address 0x1230, next instr_pc 0x1230.
- mem_ready toggled pseudo-randomly with random instr_ready, 2000 cycles → instruction stream matches a memory model at consecutive addresses; count never exceeds DEPTH.
- halt pulse with 3 entries buffered → mem_valid=0 immediately, 3 entries still drain. halt and wake in the same cycle → halted=0. wake → fetching resumes at the next sequential address.
- fetch_pc=0xFFFC, 3 accepted fetches → addresses 0xFFFC, 0xFFFE, 0x0000. RST asserted with a fetch in flight → returned word not enqueued, next request at RESET_VECTOR.

Source files
------------

// File: rtl/slurm_cpu_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches ahead of decode and
// buffers up to DEPTH {instruction, address} pairs for pipeline stage 0.
module slurm_cpu_fetch_queue #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int DEPTH        = 4,
  parameter int PC_INCR      = 2,
  parameter int RESET_VECTOR = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  output logic [ADDRESS_BITS-1:0]   mem_address,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  input  logic [BITS-1:0]           mem_in,
  input  logic                      load_pc,
  input  logic [ADDRESS_BITS-1:0]   pc_in,
  input  logic                      halt,
  input  logic                      wake,
  output logic [BITS-1:0]           instr_out,
  output logic [ADDRESS_BITS-1:0]   instr_pc,
  output logic [ADDRESS_BITS-1:0]   instr_pc_plus,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic                      halted,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]           DEPTH_C = CW'(DEPTH);
  localparam logic [ADDRESS_BITS-1:0] INCR_C  = ADDRESS_BITS'(PC_INCR);
  localparam logic [ADDRESS_BITS-1:0] RESET_C = ADDRESS_BITS'(RESET_VECTOR);

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALTED
  } fetch_state_t;

  fetch_state_t state, state_next;

  logic [ADDRESS_BITS-1:0] fetch_pc;
  logic [ADDRESS_BITS-1:0] tag_addr;
  logic                    inflight;
  logic [CW-1:0]           count;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;

  logic [BITS-1:0]         data_q [DEPTH];
  logic [ADDRESS_BITS-1:0] addr_q [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // Halt/wake control; wake has priority when both pulse together.
  always_ff @(posedge CLK) begin
    if (RST) state <= FETCH_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (wake)      state_next = FETCH_RUN;
    else if (halt) state_next = FETCH_HALTED;
  end

  assign halted = (state == FETCH_HALTED);

  // Issue is gated on buffered plus in-flight words so the FIFO cannot overflow.
  assign occupancy   = count + CW'(inflight);
  assign mem_valid   = !halted && !load_pc && (occupancy < DEPTH_C);
  assign mem_address = fetch_pc;
  assign accept      = mem_valid && mem_ready;

  assign instr_valid = (count != '0);
  assign push        = inflight && !load_pc;
  assign pop         = instr_valid && instr_ready && !load_pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc <= RESET_C;
      tag_addr <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) tag_addr <= fetch_pc;
      if (load_pc)     fetch_pc <= pc_in;
      else if (accept) fetch_pc <= fetch_pc + INCR_C;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (load_pc) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      data_q[wr_ptr] <= mem_in;
      addr_q[wr_ptr] <= tag_addr;
    end
  end

  assign instr_out     = instr_valid ? data_q[rd_ptr] : '0;
  assign instr_pc      = instr_valid ? addr_q[rd_ptr] : '0;
  assign instr_pc_plus = instr_pc + INCR_C;

endmodule

// File: tb/tb_slurm_cpu_fetch_queue.sv
// Bench for slurm_cpu_fetch_queue: directed vector table plus randomized run
// against a queue-based reference model and an address-hashing memory.
module tb_slurm_cpu_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_address;
  logic        mem_valid;
  logic        mem_ready;
  logic [15:0] mem_in;
  logic        load_pc;
  logic [15:0] pc_in;
  logic        halt;
  logic        wake;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic [15:0] instr_pc_plus;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic [2:0]  occupancy;

  slurm_cpu_fetch_queue #(
    .BITS(16), .ADDRESS_BITS(16), .DEPTH(DEPTH), .PC_INCR(2), .RESET_VECTOR(0)
  ) dut (
    .CLK(clk), .RST(rst),
    .mem_address(mem_address), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_in(mem_in), .load_pc(load_pc), .pc_in(pc_in),
    .halt(halt), .wake(wake),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_pc_plus(instr_pc_plus),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .halted(halted), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, mr, ir, ld, h, w;
    logic [15:0] pc;
    bit          chk;
    bit          mv;
    logic [15:0] addr;
    bit          iv;
    logic [15:0] ipc;
    int          occ;
    bit          hl;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];

  int checks = 0;
  int errors = 0;

  bit          known = 0;
  logic [15:0] m_pc, m_tag;
  bit          m_inflight, m_halted;
  bit          ret_valid = 0;
  logic [15:0] ret_addr = '0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [31:0] p;
    p = a * 32'h9E37 + 32'h1234;
    return p[23:8] ^ {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(bit r, bit mr, bit ir, bit ld, logic [15:0] pc, bit h, bit w,
                              bit c, bit mv, logic [15:0] addr, bit iv, logic [15:0] ipc,
                              int occ, bit hl);
    vec_t v;
    v.rst = r; v.mr = mr; v.ir = ir; v.ld = ld; v.pc = pc; v.h = h; v.w = w;
    v.chk = c; v.mv = mv; v.addr = addr; v.iv = iv; v.ipc = ipc; v.occ = occ; v.hl = hl;
    vecs.push_back(v);
  endfunction

  task automatic step(input vec_t v, input int idx);
    bit          e_mv, e_iv, acc, dut_acc;
    int          e_occ;
    logic [15:0] e_ipc, e_iout, dut_addr;
    @(negedge clk);
    rst = v.rst; mem_ready = v.mr; instr_ready = v.ir; load_pc = v.ld;
    pc_in = v.pc; halt = v.h; wake = v.w;
    mem_in = ret_valid ? memf(ret_addr) : 16'($urandom);
    #1;
    e_occ = mq.size() + int'(m_inflight);
    e_mv  = !m_halted && !v.ld && (e_occ < DEPTH);
    e_iv  = (mq.size() != 0);
    e_ipc  = e_iv ? mq[0].a : 16'h0;
    e_iout = e_iv ? mq[0].d : 16'h0;
    if (known) begin
      chk("mem_valid", mem_valid, e_mv);
      chk("mem_address", mem_address, m_pc);
      chk("occupancy", occupancy, e_occ);
      chk("instr_valid", instr_valid, e_iv);
      chk("instr_pc", instr_pc, e_ipc);
      chk("instr_out", instr_out, e_iout);
      chk("instr_pc_plus", instr_pc_plus, 16'(e_ipc + 16'd2));
      chk("halted", halted, m_halted);
    end
    if (idx >= 0 && v.chk) begin
      chk($sformatf("tab%0d_mem_valid", idx), mem_valid, v.mv);
      chk($sformatf("tab%0d_mem_address", idx), mem_address, v.addr);
      chk($sformatf("tab%0d_instr_valid", idx), instr_valid, v.iv);
      chk($sformatf("tab%0d_instr_pc", idx), instr_pc, v.ipc);
      chk($sformatf("tab%0d_occupancy", idx), occupancy, v.occ);
      chk($sformatf("tab%0d_halted", idx), halted, v.hl);
    end
    dut_acc  = (mem_valid === 1'b1) && v.mr;
    dut_addr = mem_address;
    @(posedge clk);
    if (v.rst) begin
      mq.delete();
      m_pc = 16'h0; m_tag = 16'h0; m_inflight = 0; m_halted = 0;
      known = 1;
    end else if (known) begin
      acc = e_mv && v.mr;
      if (v.ld) mq.delete();
      else begin
        if (e_iv && v.ir) void'(mq.pop_front());
        if (m_inflight) mq.push_back('{a: m_tag, d: memf(m_tag)});
      end
      m_inflight = acc;
      if (acc) m_tag = m_pc;
      if (v.ld)     m_pc = v.pc;
      else if (acc) m_pc = m_pc + 16'd2;
      if (v.w)      m_halted = 0;
      else if (v.h) m_halted = 1;
    end
    ret_valid = dut_acc;
    ret_addr  = dut_addr;
  endtask

  initial begin
    vec_t rv;
    rst = 1; mem_ready = 0; instr_ready = 0; load_pc = 0; pc_in = '0;
    halt = 0; wake = 0; mem_in = '0;

    // Startup stream at one word per cycle
    add(1,0,0,0,0,0,0, 0,0,16'h0,0,16'h0,0,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0000,0,16'h0000,0,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0002,0,16'h0000,1,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0004,1,16'h0000,2,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0006,1,16'h0002,2,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0008,1,16'h0004,2,0);
    // Fill with back-pressure, then drain
    add(1,0,0,0,0,0,0, 0,0,16'h0,0,16'h0,0,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0000,0,16'h0000,0,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0002,0,16'h0000,1,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0004,1,16'h0000,2,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0006,1,16'h0000,3,0);
    add(0,1,0,0,0,0,0, 1,0,16'h0008,1,16'h0000,4,0);
    add(0,1,0,0,0,0,0, 1,0,16'h0008,1,16'h0000,4,0);
    add(0,1,1,0,0,0,0, 1,0,16'h0008,1,16'h0000,4,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0008,1,16'h0002,3,0);
    add(0,1,1,0,0,0,0, 1,1,16'h000A,1,16'h0004,3,0);
    add(0,1,1,0,0,0,0, 1,1,16'h000C,1,16'h0006,3,0);
    add(0,1,1,0,0,0,0, 1,1,16'h000E,1,16'h0008,3,0);
    // Redirect while 0x0008 returns into a full queue
    add(1,0,0,0,0,0,0, 0,0,16'h0,0,16'h0,0,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0000,0,16'h0000,0,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0002,0,16'h0000,1,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0004,1,16'h0000,2,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0006,1,16'h0000,3,0);
    add(0,1,0,0,0,0,0, 1,0,16'h0008,1,16'h0000,4,0);
    add(0,1,1,0,0,0,0, 1,0,16'h0008,1,16'h0000,4,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0008,1,16'h0002,3,0);
    add(0,1,0,1,16'h1230,0,0, 1,0,16'h000A,1,16'h0002,4,0);
    add(0,1,1,0,0,0,0, 1,1,16'h1230,0,16'h0000,0,0);
    add(0,1,1,0,0,0,0, 1,1,16'h1232,0,16'h0000,1,0);
    add(0,1,1,0,0,0,0, 1,1,16'h1234,1,16'h1230,2,0);
    // Halt with three buffered, halt+wake, halt then wake
    add(1,0,0,0,0,0,0, 0,0,16'h0,0,16'h0,0,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0000,0,16'h0000,0,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0002,0,16'h0000,1,0);
    add(0,1,0,0,0,0,0, 1,1,16'h0004,1,16'h0000,2,0);
    add(0,0,0,0,0,0,0, 1,1,16'h0006,1,16'h0000,3,0);
    add(0,0,0,0,0,1,0, 1,1,16'h0006,1,16'h0000,3,0);
    add(0,1,1,0,0,0,0, 1,0,16'h0006,1,16'h0000,3,1);
    add(0,1,1,0,0,0,0, 1,0,16'h0006,1,16'h0002,2,1);
    add(0,1,1,0,0,0,0, 1,0,16'h0006,1,16'h0004,1,1);
    add(0,1,1,0,0,1,1, 1,0,16'h0006,0,16'h0000,0,1);
    add(0,1,1,0,0,0,0, 1,1,16'h0006,0,16'h0000,0,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0008,0,16'h0000,1,0);
    add(0,1,1,0,0,0,0, 1,1,16'h000A,1,16'h0006,2,0);
    add(0,1,1,0,0,1,0, 1,1,16'h000C,1,16'h0008,2,0);
    add(0,1,1,0,0,0,1, 1,0,16'h000E,1,16'h000A,2,1);
    add(0,1,1,0,0,0,0, 1,1,16'h000E,1,16'h000C,1,0);
    // Address wrap, then reset with a fetch in flight
    add(1,0,0,0,0,0,0, 0,0,16'h0,0,16'h0,0,0);
    add(0,0,1,1,16'hFFFC,0,0, 1,0,16'h0000,0,16'h0000,0,0);
    add(0,1,1,0,0,0,0, 1,1,16'hFFFC,0,16'h0000,0,0);
    add(0,1,1,0,0,0,0, 1,1,16'hFFFE,0,16'h0000,1,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0000,1,16'hFFFC,2,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0002,1,16'hFFFE,2,0);
    add(1,1,1,0,0,0,0, 1,1,16'h0004,1,16'h0000,2,0);
    add(0,0,1,0,0,0,0, 1,1,16'h0000,0,16'h0000,0,0);
    add(0,0,1,0,0,0,0, 1,1,16'h0000,0,16'h0000,0,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0000,0,16'h0000,0,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0002,0,16'h0000,1,0);
    add(0,1,1,0,0,0,0, 1,1,16'h0004,1,16'h0000,2,0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    for (int n = 0; n < 2000; n++) begin
      rv.rst = ($urandom_range(0, 499) == 0);
      rv.mr  = ($urandom_range(0, 2) != 0);
      rv.ir  = ($urandom_range(0, 2) != 0);
      rv.ld  = ($urandom_range(0, 31) == 0);
      rv.pc  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : (16'($urandom) & 16'hFFFE);
      rv.h   = ($urandom_range(0, 39) == 0);
      rv.w   = ($urandom_range(0, 19) == 0);
      rv.chk = 0; rv.mv = 0; rv.addr = '0; rv.iv = 0; rv.ipc = '0; rv.occ = 0; rv.hl = 0;
      step(rv, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
